// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register state encoding and example stage bundles.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_state_e;

  // ID/EX control group; packed last in the bundle so it lands in the LSBs
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       b;
    logic       s;
    logic [2:0] alu_op;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    idex_ctrl_t  ctrl;
  } idex_bundle_t;

  localparam int unsigned IDEX_CTRL_W = $bits(idex_ctrl_t);
  localparam int unsigned IDEX_DATA_W = $bits(idex_bundle_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; only built with PIPE_STAGE_STATS_EN.
`ifdef PIPE_STAGE_STATS_EN
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with 2-entry skid buffer and flush.
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned CTRL_W        = 8,
  parameter int unsigned ZERO_ON_FLUSH = 0,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  if ((DATA_W < CTRL_W) || (DATA_W == 0) || (CNT_W == 0)) begin : g_bad_cfg
    $error("pipe_stage_reg: DATA_W must be >= CTRL_W and all widths nonzero");
  end

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [DATA_W-1:0] flush_keep;
  logic [DATA_W-1:0] gate_mask;
  logic              in_fire;
  logic              out_fire;

  // Both handshake outputs decode the state register only
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    flush_keep = '0;
    gate_mask  = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      flush_keep[i] = (i >= CTRL_W) && (ZERO_ON_FLUSH == 0);
      gate_mask[i]  = (i >= CTRL_W) || out_valid;
    end
  end

  assign out_data = main_q & gate_mask;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q & flush_keep;
      skid_d  = skid_q & flush_keep;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .clr   (stats_clr),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid),
    .clr   (stats_clr),
    .cnt   (bubble_cnt)
  );
`endif

endmodule
